// File: rtl/uart_rx_line_capture.sv
// uart_rx_line_capture
// Receives 8N1 frames from a UART TX line, flags framing errors and start-bit
// glitches, and assembles the received characters into a line buffer. Each
// completed line is handed to a reader through a valid/ack handshake.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | timing to mid start bit, then confirming it is still low
// DATA      | sampling eight data bits, LSB first, one per bit time
// STOP      | timing to mid stop bit, then checking it is high
// WAIT_HIGH | stop bit was low (framing error or break), wait for line high
//
// The bit timer is a down-counter. It is loaded with the interval minus one
// and the sample point is its terminal count of zero. The sample points are
// the same as those of an up-counter that starts at zero.

module uart_rx_line_capture #(
  parameter int BAUD_DIV = 868,
  parameter int STRLEN   = 80
) (
  input  logic                         soc_clk,
  input  logic                         soc_reset,
  input  logic                         rx,
  output logic                         byte_valid,
  output logic [7:0]                   byte_data,
  output logic                         frame_err,
  output logic                         line_valid,
  output logic [$clog2(STRLEN+1)-1:0]  line_len,
  input  logic                         line_ack,
  input  logic [$clog2(STRLEN)-1:0]    line_rd_addr,
  output logic [7:0]                   line_rd_data,
  output logic [15:0]                  drop_cnt
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int LW = $clog2(STRLEN + 1);
  localparam int AW = $clog2(STRLEN);

  localparam logic [CW-1:0] HALF_TC = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(BAUD_DIV - 1);
  localparam logic [AW-1:0] LAST_WP = AW'(STRLEN - 1);
  localparam logic [LW-1:0] FULL_LEN = LW'(STRLEN);

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bidx;
  logic [7:0]      shreg;
  logic            rx_meta;
  logic            rx_s;

  logic [AW-1:0]   wp;
  logic [7:0]      buffer [STRLEN];

  // Two-flop synchroniser for the asynchronous serial input; resets to idle-high.
  always_ff @(posedge soc_clk or posedge soc_reset) begin
    if (soc_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame receiver FSM with registered byte/frame-error pulses.
  always_ff @(posedge soc_clk or posedge soc_reset) begin
    if (soc_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bidx       <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF_TC;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= FULL_TC;
              bidx  <= '0;
            end else begin
              // Start bit did not last half a bit time: treat it as a glitch.
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= FULL_TC;
            if (bidx == 3'd7) begin
              state <= STOP;
            end else begin
              bidx <= bidx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Line assembly: write pointer, line handshake and drop counter.
  always_ff @(posedge soc_clk or posedge soc_reset) begin
    if (soc_reset) begin
      line_valid <= 1'b0;
      line_len   <= '0;
      wp         <= '0;
      drop_cnt   <= '0;
    end else begin
      if (line_valid) begin
        // A pending line freezes the buffer. A byte that arrives in the same
        // cycle as the ack is still dropped.
        if (line_ack) begin
          line_valid <= 1'b0;
        end
        if (byte_valid && (drop_cnt != 16'hFFFF)) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end else if (byte_valid) begin
        if (byte_data == CHAR_LF) begin
          line_valid <= 1'b1;
          line_len   <= LW'(wp);
          wp         <= '0;
        end else if (byte_data != CHAR_CR) begin
          if (wp == LAST_WP) begin
            line_valid <= 1'b1;
            line_len   <= FULL_LEN;
            wp         <= '0;
          end else begin
            wp <= wp + 1'b1;
          end
        end
      end
    end
  end

  // Character storage. It has no reset, so contents are undefined until written.
  always_ff @(posedge soc_clk) begin
    if (byte_valid && !line_valid && (byte_data != CHAR_CR) && (byte_data != CHAR_LF)) begin
      buffer[wp] <= byte_data;
    end
  end

  assign line_rd_data = buffer[line_rd_addr];

endmodule

// File: tb/tb_uart_rx_line_capture.sv
// Directed self-checking bench for uart_rx_line_capture (BAUD_DIV=16, STRLEN=4).

module tb_uart_rx_line_capture;

  localparam int BD = 16;
  localparam int SL = 4;

  logic        soc_clk = 1'b0;
  logic        soc_reset;
  logic        rx;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;
  logic        line_valid;
  logic [2:0]  line_len;
  logic        line_ack;
  logic [1:0]  line_rd_addr;
  logic [7:0]  line_rd_data;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int last_bv_cyc = 0;
  int lv_rise_cyc = 0;
  int t_start = 0;
  logic lv_prev = 1'b0;

  int b0;
  int f0;
  int lat;
  logic [7:0] a5;

  uart_rx_line_capture #(.BAUD_DIV(BD), .STRLEN(SL)) dut (
    .soc_clk      (soc_clk),
    .soc_reset    (soc_reset),
    .rx           (rx),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .frame_err    (frame_err),
    .line_valid   (line_valid),
    .line_len     (line_len),
    .line_ack     (line_ack),
    .line_rd_addr (line_rd_addr),
    .line_rd_data (line_rd_data),
    .drop_cnt     (drop_cnt)
  );

  always #5 soc_clk = ~soc_clk;

  // Pulse monitor sampled on the falling edge, away from the active edge.
  always @(negedge soc_clk) begin
    cyc = cyc + 1;
    if (byte_valid === 1'b1) begin
      bv_cnt = bv_cnt + 1;
      last_bv_cyc = cyc;
    end
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (line_valid === 1'b1 && lv_prev !== 1'b1) lv_rise_cyc = cyc;
    lv_prev = line_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge soc_clk);
    #1;
  endtask

  // Sends one frame. A nonzero stop_low holds the stop bit low for that many
  // cycles before the line returns high.
  task automatic send(input logic [7:0] d, input int stop_low);
    @(negedge soc_clk);
    rx = 1'b0;
    t_start = cyc;
    repeat (BD) @(negedge soc_clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BD) @(negedge soc_clk);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      repeat (stop_low) @(negedge soc_clk);
    end
    rx = 1'b1;
    repeat (BD) @(negedge soc_clk);
  endtask

  task automatic rd(input logic [1:0] addr, input string tag, input logic [7:0] exp);
    line_rd_addr = addr;
    #1;
    check(tag, {24'd0, line_rd_data}, {24'd0, exp});
  endtask

  task automatic ack_line(input string tag);
    @(negedge soc_clk);
    line_ack = 1'b1;
    settle(1);
    check(tag, {31'd0, line_valid}, 32'd0);
    line_ack = 1'b0;
  endtask

  initial begin
    rx = 1'b1;
    line_ack = 1'b0;
    line_rd_addr = '0;
    soc_reset = 1'b1;
    a5 = 8'hA5;
    settle(3);
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_byte_data", {24'd0, byte_data}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_line_valid", {31'd0, line_valid}, 32'd0);
    check("rst_line_len", {29'd0, line_len}, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    @(negedge soc_clk);
    soc_reset = 1'b0;
    settle(5);

    // "Hi\n"
    b0 = bv_cnt;
    send(8'h48, 0);
    send(8'h69, 0);
    send(8'h0A, 0);
    settle(2);
    lat = last_bv_cyc - t_start;
    check("hi_bv_count", bv_cnt - b0, 32'd3);
    check("hi_byte_latency", {31'd0, (lat >= 153 && lat <= 157)}, 32'd1);
    check("hi_byte_data", {24'd0, byte_data}, 32'h0A);
    check("hi_line_valid", {31'd0, line_valid}, 32'd1);
    check("hi_line_len", {29'd0, line_len}, 32'd2);
    check("hi_lv_delay", lv_rise_cyc - last_bv_cyc, 32'd1);
    rd(2'd0, "hi_rd0", 8'h48);
    rd(2'd1, "hi_rd1", 8'h69);
    ack_line("hi_ack");
    check("hi_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    // "A\r\n"
    send(8'h41, 0);
    send(8'h0D, 0);
    send(8'h0A, 0);
    settle(2);
    check("cr_line_valid", {31'd0, line_valid}, 32'd1);
    check("cr_line_len", {29'd0, line_len}, 32'd1);
    rd(2'd0, "cr_rd0", 8'h41);
    ack_line("cr_ack");

    // Empty line
    send(8'h0A, 0);
    settle(2);
    check("empty_line_valid", {31'd0, line_valid}, 32'd1);
    check("empty_line_len", {29'd0, line_len}, 32'd0);
    ack_line("empty_ack");

    // "abcdef" with no LF: buffer fills on 'd'
    send(8'h61, 0);
    send(8'h62, 0);
    send(8'h63, 0);
    check("full_not_yet", {31'd0, line_valid}, 32'd0);
    send(8'h64, 0);
    settle(2);
    check("full_line_valid", {31'd0, line_valid}, 32'd1);
    check("full_line_len", {29'd0, line_len}, 32'd4);
    check("full_lv_delay", lv_rise_cyc - last_bv_cyc, 32'd1);
    rd(2'd3, "full_rd3", 8'h64);
    send(8'h65, 0);
    send(8'h66, 0);
    settle(2);
    check("full_drop_cnt", {16'd0, drop_cnt}, 32'd2);
    check("full_len_frozen", {29'd0, line_len}, 32'd4);
    rd(2'd0, "full_rd0_frozen", 8'h61);
    rd(2'd3, "full_rd3_frozen", 8'h64);
    ack_line("full_ack");

    // Framing error: stop bit low for three bit times
    b0 = bv_cnt;
    f0 = fe_cnt;
    send(8'h55, 3 * BD);
    settle(2);
    check("ferr_pulses", fe_cnt - f0, 32'd1);
    check("ferr_no_byte", bv_cnt - b0, 32'd0);
    send(8'h41, 0);
    settle(2);
    check("ferr_recover_count", bv_cnt - b0, 32'd1);
    check("ferr_recover_data", {24'd0, byte_data}, 32'h41);

    // Glitch of BD/4 cycles on an idle line
    b0 = bv_cnt;
    f0 = fe_cnt;
    @(negedge soc_clk);
    rx = 1'b0;
    repeat (BD / 4) @(negedge soc_clk);
    rx = 1'b1;
    settle(3 * BD);
    check("glitch_no_byte", bv_cnt - b0, 32'd0);
    check("glitch_no_ferr", fe_cnt - f0, 32'd0);
    check("glitch_no_line", {31'd0, line_valid}, 32'd0);
    send(8'h42, 0);
    send(8'h0A, 0);
    settle(2);
    check("glitch_then_bytes", bv_cnt - b0, 32'd2);
    check("glitch_line_len", {29'd0, line_len}, 32'd2);
    rd(2'd0, "glitch_rd0", 8'h41);
    rd(2'd1, "glitch_rd1", 8'h42);
    check("prereset_line_valid", {31'd0, line_valid}, 32'd1);

    // Reset during bit 4 of 0xA5, with a line still pending
    @(negedge soc_clk);
    rx = 1'b0;
    repeat (BD) @(negedge soc_clk);
    for (int i = 0; i < 4; i++) begin
      rx = a5[i];
      repeat (BD) @(negedge soc_clk);
    end
    rx = a5[4];
    repeat (BD / 2) @(negedge soc_clk);
    soc_reset = 1'b1;
    rx = 1'b1;
    settle(3);
    check("midrst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("midrst_byte_data", {24'd0, byte_data}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_line_valid", {31'd0, line_valid}, 32'd0);
    check("midrst_line_len", {29'd0, line_len}, 32'd0);
    check("midrst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    @(negedge soc_clk);
    soc_reset = 1'b0;
    settle(BD);
    b0 = bv_cnt;
    f0 = fe_cnt;
    send(8'h3C, 0);
    settle(2);
    check("postrst_bv_count", bv_cnt - b0, 32'd1);
    check("postrst_no_ferr", fe_cnt - f0, 32'd0);
    check("postrst_byte_data", {24'd0, byte_data}, 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_line_capture.md
# uart_rx_line_capture

Receive-side UART line capture that consumes the SoC `UART_TX` serial line in the simulation top. It deserialises 8N1 frames, flags framing errors and glitches, and assembles characters into a line buffer. It hands each completed line (LF-terminated or STRLEN-full) to a reader through a valid/ack handshake. It is synthesizable RTL so the same block can run in the bench and in FPGA loopback builds.

## Interface
- `BAUD_DIV`, 868, soc_clk cycles per bit; must be ≥ 4.
- `STRLEN`, 80, line buffer depth in characters; must be ≥ 2.
- `soc_clk`  in  1  sole clock; all logic is rising-edge.
- `soc_reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input, idle high, asynchronous to soc_clk.
- `byte_valid`  out  1  one-cycle pulse when a byte is accepted.
- `byte_data`  out  8  received byte; held until the next accepted byte.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `line_valid`  out  1  a completed line is available; held until acked.
- `line_len`  out  $clog2(STRLEN+1)  character count of the held line, LF excluded.
- `line_ack`  in  1  reader releases the line; sampled only while `line_valid` is high.
- `line_rd_addr`  in  $clog2(STRLEN)  read index into the held line.
- `line_rd_data`  out  8  combinational read of buffer[line_rd_addr].
- `drop_cnt`  out  16  saturating count of bytes dropped while a line was pending.

## Operation
- **Input sync.** `rx` passes through a 2-flop synchroniser (`rx_s`) with reset value 1.
- **Bit timer.** A counter `cnt` of width $clog2(BAUD_DIV) and a bit index `bidx` (0..7).
- **State machine:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rx_s`=0, go to START and set cnt=0.
  - START: at cnt=BAUD_DIV/2−1 (integer division), sample `rx_s`.
    - 0: go to DATA, cnt=0, bidx=0.
    - 1: glitch; return to IDLE with no output.
  - DATA: at cnt=BAUD_DIV−1, shift `rx_s` into the shift register, LSB first, and set cnt=0.
    - After bidx=7, go to STOP; otherwise increment bidx.
  - STOP: at cnt=BAUD_DIV−1, sample `rx_s`.
    - 1: pulse `byte_valid`, load `byte_data`, go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This covers line breaks.
- **Line assembly.** Acts on each `byte_valid` with write pointer `wp`:
  - 0x0D: ignored.
  - 0x0A: `line_valid`=1, `line_len`=wp, wp=0. An empty line (wp=0) is still reported with len 0.
  - Any other byte: buffer[wp]=byte, wp++. If wp reaches STRLEN, raise `line_valid` with len STRLEN and set wp=0.
- **Pending line.** While `line_valid`=1:
  - Accepted bytes are not stored, and `drop_cnt` increments, saturating at 0xFFFF.
  - The buffer and `line_len` stay frozen.
  - The UART FSM keeps running.
- **Release.** `line_ack`=1 while `line_valid`=1 clears `line_valid` on the next edge. `line_ack` while `line_valid`=0 is ignored.
- **Simultaneous ack and byte.** If `line_ack` and `byte_valid` occur in the same cycle, the ack takes effect and that byte is dropped and counted.

## Timing
- **Reset values:** state=IDLE, `byte_valid`=0, `byte_data`=0, `frame_err`=0, `line_valid`=0, `line_len`=0, `drop_cnt`=0, wp=0.
- `line_rd_data` after reset reads buffer contents, which are undefined. The buffer has no reset.
- **Latency.** `byte_valid` rises on the clock edge that samples the stop bit. That is 2 (sync) + BAUD_DIV/2 + 9·BAUD_DIV cycles after the falling edge of `rx`, ±1 cycle of synchroniser uncertainty.
- `line_valid` rises one cycle after the `byte_valid` of the LF or STRLEN-th character.
- **Back-to-back frames.** A new start bit is detected in the cycle after STOP returns to IDLE. The FSM therefore tolerates stop bits of ≥ BAUD_DIV/2+2 cycles.
- **Reset mid-frame.** The FSM goes to IDLE and any partial byte is lost. If `rx` is low when reset releases, the FSM enters START and the start-bit check filters the partial frame.

## Test plan
- **Single line.** BAUD_DIV=16; send "Hi\n" (0x48, 0x69, 0x0A).
  - Three `byte_valid` pulses.
  - `line_valid`=1 with `line_len`=2; rd_addr 0/1 read 0x48/0x69.
  - Assert `line_ack`; `line_valid`=0 the next cycle.
- **CR handling.** Send "A\r\n" -> `line_len`=1, buffer[0]=0x41, no entry for 0x0D.
- **Buffer full.** STRLEN=4; send "abcdef" with no LF.
  - `line_valid` rises after 'd' with `line_len`=4.
  - Without ack, 'e' and 'f' are dropped and `drop_cnt`=2.
- **Framing error.** Send 0x55 with the stop bit held low for 3 bit times.
  - `frame_err` pulses once and there is no `byte_valid`.
  - After `rx` returns high, 0x41 is received correctly.
- **Glitch rejection.** Drive a low pulse of BAUD_DIV/4 cycles on an idle line -> no outputs, FSM back in IDLE.
- **Reset mid-frame.** Assert `soc_reset` during bit 4 of 0xA5.
  - All outputs return to reset values.
  - The next full 0x3C frame yields `byte_data`=0x3C.
